// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU, forwarding-select and result-select types
// Imported by id_ex_operand_stage and forward_unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_LUI = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef logic [1:0] result_src_t;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - picks the operand source for rs1/rs2 from EX/MEM, MEM/WB or the register file
// Only compiled in when FORWARDING_EN is defined.
`ifdef FORWARDING_EN
module forward_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  exmem_reg_write,
  input  logic [ADDR_WIDTH-1:0] exmem_rd,
  input  logic                  memwb_reg_write,
  input  logic [ADDR_WIDTH-1:0] memwb_rd,
  output fwd_sel_t              fwd1_sel,
  output fwd_sel_t              fwd2_sel
);

  // x0 is hardwired zero, so a write to it is never a valid forward source
  function automatic fwd_sel_t pick(input logic [ADDR_WIDTH-1:0] rs);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd1_sel = pick(rs1);
    fwd2_sel = pick(rs2);
  end

endmodule
`endif

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with EX operand selection and branch target
// Optional forwarding from EX/MEM and MEM/WB when FORWARDING_EN is defined.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [2:0]            id_alu_ctrl,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_write,
  input  logic [1:0]            id_result_src,
  input  logic                  id_branch,
  input  logic                  exmem_reg_write,
  input  logic [ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0] exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0] memwb_result,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [2:0]            ALUctrl,
  output logic [DATA_WIDTH-1:0] ex_store_data,
  output logic [DATA_WIDTH-1:0] ex_branch_tgt,
  output logic                  ex_valid,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_write,
  output logic [1:0]            ex_result_src,
  output logic                  ex_branch
);

  logic [DATA_WIDTH-1:0] ex_rd1;
  logic [DATA_WIDTH-1:0] ex_rd2;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic [ADDR_WIDTH-1:0] ex_rs1;
  logic [ADDR_WIDTH-1:0] ex_rs2;
  alu_ctrl_t             ex_alu_ctrl;
  logic                  ex_alu_src;
  result_src_t           ex_rsrc;

  logic [DATA_WIDTH-1:0] fwd1;
  logic [DATA_WIDTH-1:0] fwd2;

  // Flush zeroes the data fields too, so a bubble looks identical to reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid     <= 1'b0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_alu_ctrl  <= ALU_ADD;
      ex_alu_src   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rsrc      <= '0;
      ex_branch    <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_rd1       <= id_rd1;
      ex_rd2       <= id_rd2;
      ex_imm       <= id_imm;
      ex_pc        <= id_pc;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_alu_ctrl  <= alu_ctrl_t'(id_alu_ctrl);
      ex_alu_src   <= id_alu_src;
      // Side-effecting controls are gated so a non-valid slot stays inert
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_write <= id_valid & id_mem_write;
      ex_rsrc      <= id_result_src;
      ex_branch    <= id_valid & id_branch;
    end
  end

`ifdef FORWARDING_EN
  fwd_sel_t fwd1_sel;
  fwd_sel_t fwd2_sel;

  forward_unit #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_forward_unit (
    .rs1            (ex_rs1),
    .rs2            (ex_rs2),
    .exmem_reg_write(exmem_reg_write),
    .exmem_rd       (exmem_rd),
    .memwb_reg_write(memwb_reg_write),
    .memwb_rd       (memwb_rd),
    .fwd1_sel       (fwd1_sel),
    .fwd2_sel       (fwd2_sel)
  );

  always_comb begin
    fwd1 = ex_rd1;
    fwd2 = ex_rd2;
    case (fwd1_sel)
      FWD_EXMEM: fwd1 = exmem_result;
      FWD_MEMWB: fwd1 = memwb_result;
      default:   fwd1 = ex_rd1;
    endcase
    case (fwd2_sel)
      FWD_EXMEM: fwd2 = exmem_result;
      FWD_MEMWB: fwd2 = memwb_result;
      default:   fwd2 = ex_rd2;
    endcase
  end
`else
  logic unused_fwd;

  assign fwd1       = ex_rd1;
  assign fwd2       = ex_rd2;
  assign unused_fwd = ^{ex_rs1, ex_rs2, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
`endif

  assign ALUop1        = fwd1;
  assign ALUop2        = ex_alu_src ? ex_imm : fwd2;
  assign ALUctrl       = ex_alu_ctrl;
  assign ex_store_data = fwd2;
  assign ex_branch_tgt = ex_pc + ex_imm;
  assign ex_result_src = ex_rsrc;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage with a behavioural reference model
// Expectations follow FORWARDING_EN the same way the design does.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int VW = 1 + AW + 1 + 1 + 2 + 1 + 3 + 4 * DW;

  logic          clk = 1'b0;
  logic          rst, stall, flush, id_valid;
  logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]    id_alu_ctrl;
  logic          id_alu_src, id_reg_write, id_mem_write, id_branch;
  logic [1:0]    id_result_src;
  logic          exmem_reg_write, memwb_reg_write;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] ALUop1, ALUop2, ex_store_data, ex_branch_tgt;
  logic [2:0]    ALUctrl;
  logic          ex_valid, ex_reg_write, ex_mem_write, ex_branch;
  logic [AW-1:0] ex_rd;
  logic [1:0]    ex_result_src;

  int checks = 0;
  int errors = 0;

  id_ex_operand_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_pc(id_pc), .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_result_src(id_result_src),
    .id_branch(id_branch), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .ex_store_data(ex_store_data), .ex_branch_tgt(ex_branch_tgt), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_result_src(ex_result_src), .ex_branch(ex_branch)
  );

  always #5 clk = ~clk;

  // What the EX stage currently holds, in instruction terms
  typedef struct {
    bit          valid;
    logic [DW-1:0] rd1, rd2, imm, pc;
    logic [AW-1:0] rs1, rs2, rd;
    logic [2:0]  ctrl;
    bit          alu_src, reg_write, mem_write, branch;
    logic [1:0]  rsrc;
  } ex_instr_t;

  ex_instr_t m;

  wire [VW-1:0] actual = {ex_valid, ex_rd, ex_reg_write, ex_mem_write, ex_result_src,
                          ex_branch, ALUctrl, ALUop1, ALUop2, ex_store_data, ex_branch_tgt};

  function automatic logic [DW-1:0] model_operand(input logic [AW-1:0] rs, input logic [DW-1:0] rv);
`ifdef FORWARDING_EN
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
`endif
    return rv;
  endfunction

  function automatic logic [VW-1:0] expected();
    logic [DW-1:0] a = model_operand(m.rs1, m.rd1);
    logic [DW-1:0] b = model_operand(m.rs2, m.rd2);
    logic [DW-1:0] tgt = DW'(m.pc + m.imm);
    return {m.valid, m.rd, m.reg_write, m.mem_write, m.rsrc, m.branch, m.ctrl,
            a, (m.alu_src ? m.imm : b), b, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst || flush) begin
      m = '{default: '0};
    end else if (!stall) begin
      m.valid     = id_valid;
      m.rd1       = id_rd1;
      m.rd2       = id_rd2;
      m.imm       = id_imm;
      m.pc        = id_pc;
      m.rs1       = id_rs1;
      m.rs2       = id_rs2;
      m.rd        = id_rd;
      m.ctrl      = id_alu_ctrl;
      m.alu_src   = id_alu_src;
      m.reg_write = id_valid && id_reg_write;
      m.mem_write = id_valid && id_mem_write;
      m.branch    = id_valid && id_branch;
      m.rsrc      = id_result_src;
    end
    #1;
  endtask

  task automatic randomize_id();
    id_valid      = 1'($urandom);
    id_rd1        = $urandom;
    id_rd2        = $urandom;
    id_imm        = $urandom;
    id_pc         = $urandom;
    id_rs1        = AW'($urandom_range(0, 3));
    id_rs2        = AW'($urandom_range(0, 3));
    id_rd         = AW'($urandom);
    id_alu_ctrl   = 3'($urandom);
    id_alu_src    = 1'($urandom);
    id_reg_write  = 1'($urandom);
    id_mem_write  = 1'($urandom);
    id_result_src = 2'($urandom);
    id_branch     = 1'($urandom);
  endtask

  task automatic quiet_fwd();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic load_instr(input logic [AW-1:0] rs1, input logic [DW-1:0] rd1,
                            input logic [AW-1:0] rs2, input logic [DW-1:0] rd2,
                            input logic [DW-1:0] imm, input logic alu_src);
    rst = 0; stall = 0; flush = 0;
    randomize_id();
    id_valid = 1; id_rs1 = rs1; id_rd1 = rd1; id_rs2 = rs2; id_rd2 = rd2;
    id_imm = imm; id_alu_src = alu_src; id_alu_ctrl = 3'b000; id_reg_write = 1;
    tick();
  endtask

  task automatic test_reset();
    randomize_id();
    id_valid = 1; id_reg_write = 1; id_mem_write = 1; id_branch = 1; id_rs1 = 5'd7;
    exmem_reg_write = 1; exmem_rd = 5'd9; exmem_result = 32'h1234;
    memwb_reg_write = 1; memwb_rd = 5'd10; memwb_result = 32'h5678;
    stall = 1; flush = 0; rst = 1;
    tick();
    tick();
    checks++;
    if (actual !== '0) begin
      errors++;
      $display("FAIL reset_outputs actual=%h required=0", actual);
    end
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid actual=%b required=0", ex_valid);
    end
    rst = 0; stall = 0;
    quiet_fwd();
  endtask

  task automatic test_capture();
    randomize_id();
    id_valid = 1; id_rs1 = 5'd1; id_rd1 = 32'd5; id_imm = 32'd7; id_alu_src = 1; id_alu_ctrl = 3'b000;
    #1;
    checks++;
    if (ALUop1 !== 32'd0) begin
      errors++;
      $display("FAIL capture_latency actual=%h required=0", ALUop1);
    end
    tick();
    checks++;
    if (ALUop1 !== 32'd5 || ALUop2 !== 32'd7 || ALUctrl !== 3'b000 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL capture op1=%0d op2=%0d ctrl=%b valid=%b required 5 7 000 1",
               ALUop1, ALUop2, ALUctrl, ex_valid);
    end
  endtask

  task automatic test_stall();
    logic [VW-1:0] frozen;
    load_instr(5'd2, 32'hCAFE, 5'd3, 32'hBEEF, 32'h40, 1'b0);
    frozen = actual;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      tick();
      checks++;
      if (actual !== frozen) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d actual=%h required=%h", i, actual, frozen);
      end
    end
    stall = 0;
  endtask

  task automatic test_flush_stall();
    load_instr(5'd4, 32'h11, 5'd5, 32'h22, 32'h0, 1'b0);
    id_mem_write = 1; id_branch = 1;
    tick();
    stall = 1; flush = 1;
    randomize_id();
    id_valid = 1; id_reg_write = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ex_branch !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_stall valid=%b rw=%b mw=%b br=%b required all 0",
               ex_valid, ex_reg_write, ex_mem_write, ex_branch);
    end
    flush = 0;
    load_instr(5'd4, 32'h11, 5'd5, 32'h22, 32'h9, 1'b1);
    stall = 1; rst = 1;
    tick();
    checks++;
    if (actual !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall actual=%h required=0", actual);
    end
    rst = 0; stall = 0;
  endtask

  task automatic test_forward();
    logic [DW-1:0] want_hi, want_lo;
`ifdef FORWARDING_EN
    want_hi = 32'hAA; want_lo = 32'hBB;
`else
    want_hi = 32'h11; want_lo = 32'h11;
`endif
    load_instr(5'd3, 32'h11, 5'd3, 32'h11, 32'h0, 1'b0);
    stall = 1;
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'hBB;
    #1;
    checks++;
    if (ALUop1 !== want_hi || ex_store_data !== want_hi || ALUop2 !== want_hi) begin
      errors++;
      $display("FAIL fwd_exmem_priority op1=%h store=%h op2=%h required=%h",
               ALUop1, ex_store_data, ALUop2, want_hi);
    end
    exmem_reg_write = 0;
    #1;
    checks++;
    if (ALUop1 !== want_lo || ex_store_data !== want_lo) begin
      errors++;
      $display("FAIL fwd_memwb op1=%h store=%h required=%h", ALUop1, ex_store_data, want_lo);
    end
    stall = 0;
    quiet_fwd();
  endtask

  task automatic test_x0();
    load_instr(5'd0, 32'h33, 5'd0, 32'h44, 32'h0, 1'b0);
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
    #1;
    checks++;
    if (ALUop1 !== 32'h33 || ex_store_data !== 32'h44) begin
      errors++;
      $display("FAIL x0_not_forwarded op1=%h store=%h required 33 44", ALUop1, ex_store_data);
    end
    quiet_fwd();
  endtask

  task automatic test_branch_wrap();
    rst = 0; stall = 0; flush = 0;
    randomize_id();
    id_valid = 1; id_branch = 1; id_pc = 32'hFFFF_FFFC; id_imm = 32'd8;
    tick();
    checks++;
    if (ex_branch_tgt !== 32'h0000_0004 || ex_branch !== 1'b1) begin
      errors++;
      $display("FAIL branch_wrap tgt=%h br=%b required 00000004 1", ex_branch_tgt, ex_branch);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_id();
      rst   = ($urandom_range(0, 99) < 3);
      flush = ($urandom_range(0, 99) < 10);
      stall = ($urandom_range(0, 99) < 20);
      exmem_reg_write = 1'($urandom); exmem_rd = AW'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = AW'($urandom_range(0, 3)); memwb_result = $urandom;
      #1;
      checks++;
      if (actual !== expected()) begin
        errors++;
        $display("FAIL random_cycle=%0d actual=%h required=%h", i, actual, expected());
      end
      tick();
    end
    rst = 0; flush = 0; stall = 0;
  endtask

  initial begin
    m = '{default: '0};
    rst = 1; stall = 0; flush = 0;
    randomize_id();
    quiet_fwd();
    test_reset();
    test_capture();
    test_stall();
    test_flush_stall();
    test_forward();
    test_x0();
    test_branch_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
